// File: rtl/snax_tcdm_split_port_adapter.sv
// Adapter from accelerator write-only / read-only streamer ports onto a TCDM interconnect input vector.
// Read ports gain credit-bounded response buffering, so consumers may stall their responses.
module snax_tcdm_split_port_adapter #(
   parameter int unsigned NumWr     = 16,
   parameter int unsigned NumRd     = 16,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned RspDepth  = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [NumWr-1:0]                       wr_q_valid_i,
   output logic [NumWr-1:0]                       wr_q_ready_o,
   input  logic [NumWr*AddrWidth-1:0]             wr_addr_i,
   input  logic [NumWr*DataWidth-1:0]             wr_data_i,
   input  logic [NumWr*DataWidth/8-1:0]           wr_strb_i,
   input  logic [NumRd-1:0]                       rd_q_valid_i,
   output logic [NumRd-1:0]                       rd_q_ready_o,
   input  logic [NumRd*AddrWidth-1:0]             rd_addr_i,
   output logic [NumRd-1:0]                       rd_p_valid_o,
   input  logic [NumRd-1:0]                       rd_p_ready_i,
   output logic [NumRd*DataWidth-1:0]             rd_p_data_o,
   output logic [NumWr+NumRd-1:0]                 ic_q_valid_o,
   input  logic [NumWr+NumRd-1:0]                 ic_q_ready_i,
   output logic [(NumWr+NumRd)*AddrWidth-1:0]     ic_addr_o,
   output logic [NumWr+NumRd-1:0]                 ic_write_o,
   output logic [(NumWr+NumRd)*DataWidth-1:0]     ic_data_o,
   output logic [(NumWr+NumRd)*DataWidth/8-1:0]   ic_strb_o,
   input  logic [NumWr+NumRd-1:0]                 ic_p_valid_i,
   input  logic [(NumWr+NumRd)*DataWidth-1:0]     ic_p_data_i,
   output logic                                   busy_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned CntWidth  = $clog2(RspDepth + 1);
   localparam int unsigned PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(RspDepth);
   localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(RspDepth - 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never depends on ready of the same channel, ready may depend on valid.

   logic [NumRd-1:0] busy_vec;
   logic             unused_wr_rsp;

   // Write-index responses carry nothing useful for a write-only streamer.
   assign unused_wr_rsp = ^{ic_p_valid_i[NumWr-1:0], ic_p_data_i[NumWr*DataWidth-1:0]};

   for (genvar w = 0; w < NumWr; w++) begin : g_wr
      assign ic_q_valid_o[w] = wr_q_valid_i[w];
      assign wr_q_ready_o[w] = ic_q_ready_i[w];
      assign ic_write_o[w]   = 1'b1;
      assign ic_addr_o[w*AddrWidth +: AddrWidth] = wr_addr_i[w*AddrWidth +: AddrWidth];
      assign ic_data_o[w*DataWidth +: DataWidth] = wr_data_i[w*DataWidth +: DataWidth];
      assign ic_strb_o[w*StrbWidth +: StrbWidth] = wr_strb_i[w*StrbWidth +: StrbWidth];
   end

   for (genvar r = 0; r < NumRd; r++) begin : g_rd
      localparam int unsigned K = NumWr + r;

      logic [CntWidth-1:0]  cnt_q, cnt_d;
      logic [CntWidth-1:0]  occ_q, occ_d;
      logic [PtrWidth-1:0]  rptr_q, rptr_d;
      logic [PtrWidth-1:0]  wptr_q, wptr_d;
      logic [DataWidth-1:0] mem_q [RspDepth];
      logic                 can_issue;
      logic                 acc;
      logic                 pop;
      logic                 push;

      // cnt covers in-flight plus buffered reads, so it alone guarantees FIFO space.
      assign can_issue       = (cnt_q < DepthCnt);
      assign ic_q_valid_o[K] = rd_q_valid_i[r] & can_issue;
      assign rd_q_ready_o[r] = ic_q_ready_i[K] & can_issue;
      assign ic_write_o[K]   = 1'b0;
      assign ic_addr_o[K*AddrWidth +: AddrWidth] = rd_addr_i[r*AddrWidth +: AddrWidth];
      assign ic_data_o[K*DataWidth +: DataWidth] = '0;
      assign ic_strb_o[K*StrbWidth +: StrbWidth] = '0;

      assign acc  = ic_q_valid_o[K] & ic_q_ready_i[K];
      assign push = ic_p_valid_i[K];
      assign pop  = rd_p_valid_o[r] & rd_p_ready_i[r];

      assign rd_p_valid_o[r] = (occ_q != '0);
      assign rd_p_data_o[r*DataWidth +: DataWidth] = mem_q[rptr_q];
      assign busy_vec[r] = (cnt_q != '0);

      always_comb begin
         cnt_d  = cnt_q;
         occ_d  = occ_q;
         rptr_d = rptr_q;
         wptr_d = wptr_q;
         if (acc && !pop) begin
            cnt_d = cnt_q + CntWidth'(1);
         end else if (pop && !acc) begin
            cnt_d = cnt_q - CntWidth'(1);
         end
         if (push && !pop) begin
            occ_d = occ_q + CntWidth'(1);
         end else if (pop && !push) begin
            occ_d = occ_q - CntWidth'(1);
         end
         if (pop) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrWidth'(1);
         end
         if (push) begin
            wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrWidth'(1);
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_q  <= '0;
            occ_q  <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
         end else begin
            cnt_q  <= cnt_d;
            occ_q  <= occ_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
         end
      end

      // Storage needs no reset: pointers and occupancy define what is valid.
      always_ff @(posedge clk_i) begin
         if (push) begin
            mem_q[wptr_q] <= ic_p_data_i[K*DataWidth +: DataWidth];
         end
      end

      a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
         !(push && (occ_q == DepthCnt) && !pop));
   end

   assign busy_o = |busy_vec;

endmodule

// File: tb/tb_snax_tcdm_split_port_adapter.sv
// Bench for snax_tcdm_split_port_adapter: queue-level reference model checked every cycle,
// a latency-1 memory responder, and directed scenarios with literal expectations.
module tb_snax_tcdm_split_port_adapter;

   localparam int NW    = 16;
   localparam int NR    = 16;
   localparam int AW    = 32;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int NI    = NW + NR;
   localparam int SW    = DW / 8;

   logic              clk = 1'b0;
   logic              rst_i;
   logic [NW-1:0]     wr_q_valid_i;
   logic [NW-1:0]     wr_q_ready_o;
   logic [NW*AW-1:0]  wr_addr_i;
   logic [NW*DW-1:0]  wr_data_i;
   logic [NW*SW-1:0]  wr_strb_i;
   logic [NR-1:0]     rd_q_valid_i;
   logic [NR-1:0]     rd_q_ready_o;
   logic [NR*AW-1:0]  rd_addr_i;
   logic [NR-1:0]     rd_p_valid_o;
   logic [NR-1:0]     rd_p_ready_i;
   logic [NR*DW-1:0]  rd_p_data_o;
   logic [NI-1:0]     ic_q_valid_o;
   logic [NI-1:0]     ic_q_ready_i;
   logic [NI*AW-1:0]  ic_addr_o;
   logic [NI-1:0]     ic_write_o;
   logic [NI*DW-1:0]  ic_data_o;
   logic [NI*SW-1:0]  ic_strb_o;
   logic [NI-1:0]     ic_p_valid_i;
   logic [NI*DW-1:0]  ic_p_data_i;
   logic              busy_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cycle_n = 0;

   snax_tcdm_split_port_adapter #(
      .NumWr(NW), .NumRd(NR), .AddrWidth(AW), .DataWidth(DW), .RspDepth(DEPTH)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .wr_q_valid_i(wr_q_valid_i), .wr_q_ready_o(wr_q_ready_o),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
      .rd_q_valid_i(rd_q_valid_i), .rd_q_ready_o(rd_q_ready_o), .rd_addr_i(rd_addr_i),
      .rd_p_valid_o(rd_p_valid_o), .rd_p_ready_i(rd_p_ready_i), .rd_p_data_o(rd_p_data_o),
      .ic_q_valid_o(ic_q_valid_o), .ic_q_ready_i(ic_q_ready_i), .ic_addr_o(ic_addr_o),
      .ic_write_o(ic_write_o), .ic_data_o(ic_data_o), .ic_strb_o(ic_strb_o),
      .ic_p_valid_i(ic_p_valid_i), .ic_p_data_i(ic_p_data_i), .busy_o(busy_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cycle_n, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // ---------------- memory responder (latency 1, data = zero-extended address) ----------------
   logic [NR-1:0] pend = '0;
   logic [AW-1:0] pend_addr [NR] = '{default: '0};

   always @(negedge clk) begin
      for (int r = 0; r < NR; r++) begin
         pend[r]      = !rst_i && ic_q_valid_o[NW+r] && ic_q_ready_i[NW+r];
         pend_addr[r] = ic_addr_o[(NW+r)*AW +: AW];
      end
   end

   always @(posedge clk) begin
      #1;
      for (int r = 0; r < NR; r++) begin
         ic_p_valid_i[NW+r]          = pend[r];
         ic_p_data_i[(NW+r)*DW +: DW] = {32'h0, pend_addr[r]};
      end
   end

   // ---------------- reference model: credits as integers, buffered responses as queues ----------------
   int            m_cnt  [NR];
   logic [DW-1:0] m_fifo [NR][$];

   always @(posedge clk) begin
      cycle_n++;
      for (int r = 0; r < NR; r++) begin
         if (rst_i) begin
            m_cnt[r] = 0;
            m_fifo[r].delete();
         end else begin
            bit acc;
            bit pop;
            acc = rd_q_valid_i[r] && ic_q_ready_i[NW+r] && (m_cnt[r] < DEPTH);
            pop = (m_fifo[r].size() != 0) && rd_p_ready_i[r];
            if (pop) void'(m_fifo[r].pop_front());
            if (ic_p_valid_i[NW+r]) m_fifo[r].push_back(ic_p_data_i[(NW+r)*DW +: DW]);
            m_cnt[r] = m_cnt[r] + int'(acc) - int'(pop);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cycle_n > 0) begin
         logic [NR-1:0] e_pv;
         logic [NR-1:0] e_qr;
         logic [NR-1:0] e_qv;
         logic          e_busy;
         e_busy = 1'b0;
         for (int r = 0; r < NR; r++) begin
            e_pv[r] = (m_fifo[r].size() != 0);
            e_qr[r] = ic_q_ready_i[NW+r] && (m_cnt[r] < DEPTH);
            e_qv[r] = rd_q_valid_i[r] && (m_cnt[r] < DEPTH);
            if (m_cnt[r] != 0) e_busy = 1'b1;
            if (e_pv[r]) check("rd_p_data", 128'(rd_p_data_o[r*DW +: DW]), 128'(m_fifo[r][0]));
            check("rd_ic_fields",
                  128'({ic_addr_o[(NW+r)*AW +: AW], ic_data_o[(NW+r)*DW +: DW], ic_strb_o[(NW+r)*SW +: SW]}),
                  128'({rd_addr_i[r*AW +: AW], 64'h0, 8'h0}));
         end
         check("rd_p_valid", 128'(rd_p_valid_o), 128'(e_pv));
         check("rd_q_ready", 128'(rd_q_ready_o), 128'(e_qr));
         check("ic_q_valid_rd", 128'(ic_q_valid_o[NI-1:NW]), 128'(e_qv));
         check("busy", 128'(busy_o), 128'(e_busy));
         check("ic_write", 128'(ic_write_o), 128'({{NR{1'b0}}, {NW{1'b1}}}));
         for (int w = 0; w < NW; w++) begin
            check("wr_pass",
                  128'({ic_q_valid_o[w], wr_q_ready_o[w], ic_addr_o[w*AW +: AW],
                        ic_data_o[w*DW +: DW], ic_strb_o[w*SW +: SW]}),
                  128'({wr_q_valid_i[w], ic_q_ready_i[w], wr_addr_i[w*AW +: AW],
                        wr_data_i[w*DW +: DW], wr_strb_i[w*SW +: SW]}));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   int n_acc;
   int n0_acc;
   int n_pop;

   initial begin
      rst_i        = 1'b1;
      wr_q_valid_i = '0;
      wr_addr_i    = '0;
      wr_data_i    = '0;
      wr_strb_i    = '0;
      rd_q_valid_i = '0;
      rd_addr_i    = '0;
      rd_p_ready_i = '1;
      ic_q_ready_i = '1;
      ic_p_valid_i = {{NR{1'b0}}, {NW{1'b1}}};
      ic_p_data_i  = '1;

      // reset: read ready follows the interconnect ready with zero credits used
      cyc();
      ic_q_ready_i[NW+2] = 1'b0;
      cyc();
      mid();
      check("rst_p_valid", 128'(rd_p_valid_o), 128'(0));
      check("rst_busy", 128'(busy_o), 128'(0));
      check("rst_q_ready", 128'(rd_q_ready_o), 128'(16'hFFFB));
      cyc();
      rst_i        = 1'b0;
      ic_q_ready_i = '1;

      // write pass-through on port 3
      cyc();
      wr_q_valid_i[3]          = 1'b1;
      wr_addr_i[3*AW +: AW]    = 32'h40;
      wr_data_i[3*DW +: DW]    = 64'hDEAD_BEEF;
      wr_strb_i[3*SW +: SW]    = 8'hFF;
      mid();
      check("wr3_fields",
            128'({ic_q_valid_o[3], ic_write_o[3], wr_q_ready_o[3], ic_addr_o[3*AW +: AW],
                  ic_data_o[3*DW +: DW], ic_strb_o[3*SW +: SW]}),
            128'({3'b111, 32'h40, 64'hDEAD_BEEF, 8'hFF}));
      cyc();
      ic_q_ready_i[3] = 1'b0;
      mid();
      check("wr3_stall", 128'({ic_q_valid_o[3], wr_q_ready_o[3]}), 128'(2'b10));
      cyc();
      ic_q_ready_i[3] = 1'b1;
      wr_q_valid_i    = '0;

      // single read on port 0, memory latency 1
      cyc();
      rd_q_valid_i[0]     = 1'b1;
      rd_addr_i[0 +: AW]  = 32'h1234;
      mid();
      check("rd0_issue",
            128'({ic_q_valid_o[16], rd_q_ready_o[0], ic_write_o[16], ic_strb_o[16*SW +: SW], ic_addr_o[16*AW +: AW]}),
            128'({3'b110, 8'h00, 32'h1234}));
      cyc();
      rd_q_valid_i[0] = 1'b0;
      mid();
      check("rd0_latency", 128'({rd_p_valid_o[0], ic_p_valid_i[16], busy_o}), 128'(3'b011));
      cyc();
      mid();
      check("rd0_rsp", 128'({rd_p_valid_o[0], rd_p_data_o[0 +: DW]}), 128'({1'b1, 64'h1234}));
      cyc();
      mid();
      check("rd0_done", 128'({rd_p_valid_o[0], busy_o}), 128'(2'b00));

      // credit stall on port 1
      cyc();
      rd_p_ready_i[1] = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) cyc();
         rd_q_valid_i[1]     = 1'b1;
         rd_addr_i[AW +: AW] = 32'h100 + 32'(n_acc * 8);
         mid();
         if (rd_q_ready_o[1]) n_acc++;
      end
      check("p1_accepts_full", 128'(n_acc), 128'(4));
      check("p1_stalled", 128'({rd_q_ready_o[1], ic_q_valid_o[17], rd_p_valid_o[1]}), 128'(3'b001));
      check("model_p1_cnt", 128'(m_cnt[1]), 128'(4));
      cyc();
      rd_p_ready_i[1] = 1'b1;
      mid();
      check("p1_head", 128'({rd_p_valid_o[1], rd_q_ready_o[1], rd_p_data_o[DW +: DW]}), 128'({2'b10, 64'h100}));
      for (int i = 0; i < 4; i++) begin
         cyc();
         rd_p_ready_i[1]     = 1'b0;
         rd_addr_i[AW +: AW] = 32'h100 + 32'(n_acc * 8);
         mid();
         if (rd_q_ready_o[1]) n_acc++;
      end
      check("p1_one_more", 128'(n_acc), 128'(5));
      cyc();
      rd_q_valid_i[1] = 1'b0;
      rd_p_ready_i[1] = 1'b1;
      n_pop = 0;
      for (int i = 0; i < 8; i++) begin
         mid();
         if (rd_p_valid_o[1]) begin
            check("p1_order", 128'(rd_p_data_o[DW +: DW]), 128'(64'h108 + 64'(8 * n_pop)));
            n_pop++;
         end
         cyc();
      end
      check("p1_drained", 128'(n_pop), 128'(4));

      // full throughput on port 3
      n_acc = 0;
      n_pop = 0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) cyc();
         rd_q_valid_i[3]        = 1'b1;
         rd_addr_i[3*AW +: AW]  = 32'h300 + 32'(8 * i);
         mid();
         if (rd_q_ready_o[3]) n_acc++;
         if (rd_p_valid_o[3]) begin
            check("p3_order", 128'(rd_p_data_o[3*DW +: DW]), 128'(64'h300 + 64'(8 * n_pop)));
            n_pop++;
         end
         check("p3_cnt_bound", 128'(m_cnt[3] <= 2), 128'(1));
      end
      check("p3_accepts", 128'(n_acc), 128'(20));
      cyc();
      rd_q_valid_i[3] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid();
         if (rd_p_valid_o[3]) begin
            check("p3_order", 128'(rd_p_data_o[3*DW +: DW]), 128'(64'h300 + 64'(8 * n_pop)));
            n_pop++;
         end
         cyc();
      end
      check("p3_pops", 128'(n_pop), 128'(20));

      // reset with three responses buffered on port 2
      rd_p_ready_i[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) cyc();
         rd_q_valid_i[2]       = 1'b1;
         rd_addr_i[2*AW +: AW] = 32'h200 + 32'(8 * i);
      end
      cyc();
      rd_q_valid_i[2] = 1'b0;
      cyc();
      mid();
      check("p2_buffered", 128'({rd_p_valid_o[2], busy_o, rd_p_data_o[2*DW +: DW]}), 128'({2'b11, 64'h200}));
      check("model_p2_occ", 128'(m_fifo[2].size()), 128'(3));
      cyc();
      rst_i = 1'b1;
      cyc();
      rst_i              = 1'b0;
      ic_q_ready_i[NW+2] = 1'b0;
      mid();
      check("p2_after_rst", 128'({rd_p_valid_o[2], busy_o, rd_q_ready_o[2]}), 128'(3'b000));
      cyc();
      ic_q_ready_i[NW+2] = 1'b1;
      rd_p_ready_i[2]    = 1'b1;
      mid();
      check("p2_ready_back", 128'(rd_q_ready_o[2]), 128'(1));

      // port isolation: port 0 stalled at full credits while port 5 streams
      cyc();
      rd_p_ready_i[0] = 1'b0;
      n_acc  = 0;
      n0_acc = 0;
      n_pop  = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) cyc();
         rd_q_valid_i[0]       = 1'b1;
         rd_addr_i[0 +: AW]    = 32'hA00 + 32'(8 * n0_acc);
         rd_q_valid_i[5]       = 1'b1;
         rd_addr_i[5*AW +: AW] = 32'h5000 + 32'(8 * i);
         mid();
         if (rd_q_ready_o[0]) n0_acc++;
         if (rd_q_ready_o[5]) n_acc++;
         if (rd_p_valid_o[5]) begin
            check("p5_order", 128'(rd_p_data_o[5*DW +: DW]), 128'(64'h5000 + 64'(8 * n_pop)));
            n_pop++;
         end
      end
      check("p0_accepts", 128'(n0_acc), 128'(4));
      check("p5_accepts", 128'(n_acc), 128'(10));
      cyc();
      rd_q_valid_i[0] = 1'b0;
      rd_q_valid_i[5] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mid();
         if (rd_p_valid_o[5]) begin
            check("p5_order", 128'(rd_p_data_o[5*DW +: DW]), 128'(64'h5000 + 64'(8 * n_pop)));
            n_pop++;
         end
         cyc();
      end
      check("p5_pops", 128'(n_pop), 128'(10));
      rd_p_ready_i[0] = 1'b1;
      mid();
      check("p0_still_busy", 128'(busy_o), 128'(1));
      for (int j = 0; j < 4; j++) begin
         if (j > 0) mid();
         check("p0_drain", 128'({rd_p_valid_o[0], busy_o, rd_p_data_o[0 +: DW]}),
               128'({2'b11, 64'hA00 + 64'(8 * j)}));
         cyc();
      end
      mid();
      check("p0_idle", 128'({rd_p_valid_o[0], busy_o}), 128'(2'b00));

      // mixed traffic on every port, checked by the model each cycle
      for (int i = 0; i < 60; i++) begin
         cyc();
         for (int w = 0; w < NW; w++) begin
            wr_q_valid_i[w]       = 1'($urandom_range(0, 1));
            wr_addr_i[w*AW +: AW] = 32'($urandom_range(0, 32'hFFFF));
            wr_data_i[w*DW +: DW] = {32'($urandom_range(0, 32'hFFFF)), 32'($urandom_range(0, 32'hFFFF))};
            wr_strb_i[w*SW +: SW] = 8'($urandom_range(0, 255));
            ic_q_ready_i[w]       = 1'($urandom_range(0, 1));
         end
         for (int r = 0; r < NR; r++) begin
            rd_q_valid_i[r]       = 1'($urandom_range(0, 1));
            rd_addr_i[r*AW +: AW] = 32'($urandom_range(0, 32'hFFFF));
            rd_p_ready_i[r]       = 1'($urandom_range(0, 3) != 0);
            ic_q_ready_i[NW+r]    = 1'($urandom_range(0, 1));
         end
      end
      cyc();
      wr_q_valid_i = '0;
      rd_q_valid_i = '0;
      rd_p_ready_i = '1;
      ic_q_ready_i = '1;
      repeat (8) cyc();
      mid();
      check("final_idle", 128'({busy_o, rd_p_valid_o}), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/snax_tcdm_split_port_adapter.md
Name: snax_tcdm_split_port_adapter

Overview:
- Parametrised adapter between accelerator streamer ports and a snitch_tcdm_interconnect input vector.
- Owns NumWr write-only ports and NumRd read-only ports, and forces the write bit per port class.
- Adds per-read-port outstanding-request credits and response buffering, so read consumers can apply backpressure (p_ready), which the interconnect does not support.
- Interconnect port index: write ports occupy 0..NumWr-1; read ports occupy NumWr..NumWr+NumRd-1.

Parameters:
- NumWr, 16: number of write-only ports (>=1).
- NumRd, 16: number of read-only ports (>=1).
- AddrWidth, 32: TCDM address width.
- DataWidth, 64: data width; strobe width is DataWidth/8.
- RspDepth, 4: maximum outstanding reads per read port, which is also the response FIFO depth (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- wr_q_valid_i  in  NumWr  write request valid.
- wr_q_ready_o  out  NumWr  write request ready.
- wr_addr_i  in  NumWr*AddrWidth  write address.
- wr_data_i  in  NumWr*DataWidth  write data.
- wr_strb_i  in  NumWr*DataWidth/8  write byte strobes.
- rd_q_valid_i  in  NumRd  read request valid.
- rd_q_ready_o  out  NumRd  read request ready.
- rd_addr_i  in  NumRd*AddrWidth  read address.
- rd_p_valid_o  out  NumRd  read response valid.
- rd_p_ready_i  in  NumRd  read response ready.
- rd_p_data_o  out  NumRd*DataWidth  read response data.
- ic_q_valid_o  out  NumWr+NumRd  interconnect request valid.
- ic_q_ready_i  in  NumWr+NumRd  interconnect request ready.
- ic_addr_o  out  (NumWr+NumRd)*AddrWidth  interconnect address.
- ic_write_o  out  NumWr+NumRd  interconnect write bit.
- ic_data_o  out  (NumWr+NumRd)*DataWidth  interconnect write data.
- ic_strb_o  out  (NumWr+NumRd)*DataWidth/8  interconnect strobes.
- ic_p_valid_i  in  NumWr+NumRd  interconnect response valid.
- ic_p_data_i  in  (NumWr+NumRd)*DataWidth  interconnect response data.
- busy_o  out  1  any read outstanding or buffered.

Behaviour:
- Clocking: one clock, clk_i. Reset rst_i is synchronous and active-high. All state is updated on the rising edge of clk_i.

Write ports (combinational pass-through):
- ic_q_valid_o[w] = wr_q_valid_i[w]; wr_q_ready_o[w] = ic_q_ready_i[w].
- ic_write_o[w] = 1; address, data and strobes pass through unchanged.
- ic_p_valid_i/ic_p_data_i on write indices are ignored.

Read port r, interconnect index k = NumWr+r:
- cnt[r]: width $clog2(RspDepth+1), reset 0. It counts requests accepted but whose response has not yet been popped by the consumer.
- can_issue[r] = (cnt[r] < RspDepth).
- ic_q_valid_o[k] = rd_q_valid_i[r] & can_issue[r].
- rd_q_ready_o[r] = ic_q_ready_i[k] & can_issue[r].
- ic_write_o[k] = 0; ic_data_o[k] = 0; ic_strb_o[k] = 0.
- acc = ic_q_valid_o[k] & ic_q_ready_i[k]; pop = rd_p_valid_o[r] & rd_p_ready_i[r].
- cnt update: +1 if acc & !pop; -1 if pop & !acc; unchanged if both or neither.

Response FIFO (one per read port):
- Depth RspDepth, registered (not fall-through). Pushes ic_p_data_i[k] whenever ic_p_valid_i[k] = 1.
- rd_p_valid_o[r] = FIFO non-empty; rd_p_data_o[r] = FIFO head.
- Latency: request accepted at cycle t with memory latency L gives response on ic_p_valid_i at t+L and on rd_p_valid_o at t+L+1.
- Cannot overflow by construction, since cnt bounds outstanding + buffered responses. Push while full is an assertion error.
- Simultaneous push and pop is legal when full or empty+1. Occupancy stays unchanged, with the head advancing.
- Read and write pointers wrap modulo RspDepth; RspDepth need not be a power of two.
- Responses are returned in order per port, as the interconnect guarantees in-order per input.

Reset and busy:
- busy_o = OR over r of (cnt[r] != 0), combinational.
- While rst_i = 1: all cnt = 0 and all FIFOs empty, so rd_p_valid_o = 0, busy_o = 0, and rd_q_ready_o/ic_q_valid_o on read ports follow the combinational rules with cnt = 0.
- ic_p_valid_i is ignored while rst_i = 1.
- Mid-operation reset discards buffered data. The interconnect shall be reset in the same cycle; responses to pre-reset requests arriving after reset deassertion are unsupported.

Test Plan:
- Write pass-through: wr_q_valid_i[3]=1, addr 0x40, data 0xDEAD_BEEF, strb 0xFF, ic_q_ready_i[3]=1 -> same cycle ic_q_valid_o[3]=1, ic_write_o[3]=1, fields equal, wr_q_ready_o[3]=1.
- Single read, L=1: rd_q_valid_i[0]=1 at t, ic_q_ready_i[16]=1; ic_p_valid_i[16] at t+1 with 0x1234 -> rd_p_valid_o[0]=1, data 0x1234 at t+2; ic_write_o[16]=0, ic_strb_o[16]=0.
- Credit stall, RspDepth=4: rd_p_ready_i[1]=0, continuous requests -> exactly 4 accepted, then rd_q_ready_o[1]=0 and ic_q_valid_o[17]=0. Raising rd_p_ready_i for one pop -> exactly one further request accepted; data returns in order.
- Full throughput: RspDepth=4, L=1, rd_p_ready_i=1 -> one request accepted per cycle indefinitely; cnt stays at <=2; no assertion fires.
- Reset mid-operation: 3 responses buffered on port 2, rst_i=1 for one cycle -> next cycle rd_p_valid_o[2]=0, busy_o=0, rd_q_ready_o[2]=ic_q_ready_i[18].
- Port isolation: port 0 stalled at full credits while port 5 streams -> port 5 unaffected. busy_o=1 until port 0 drains, then busy_o=0 the cycle after the last pop.
